interlude_core: RTL and testbench
=================================

# interlude_core

Parametrised successor to the 8-bit Overture-style CPU core: same 8-bit instruction encoding and register model, generalised to DATA_W-bit data and PC_W-bit program counter. Adds a multicycle FETCH/EXEC/WAIT_IO state machine, a stall-tolerant instruction-memory handshake, valid/ack flow control on register-7 I/O, extra shift ops, and a retired-instruction counter. It sits between an external instruction memory and the platform I/O.

## Interface
- DATA_W, 8, datapath/register width; must be ≥ 8.
- PC_W, 8, program-counter/instruction-address width; must be ≤ DATA_W.
- RESET_PC, 0, PC value loaded on reset.

- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request; high iff state FETCH and reset low.
- imem_addr  output  PC_W  fetch address, equal to pc.
- imem_valid  input  1  imem_data valid; may rise in the same cycle as imem_req.
- imem_data  input  8  instruction byte.
- io_in  input  DATA_W  input-port data, read as r7.
- io_in_valid  input  1  io_in holds a value.
- io_in_ack  output  1  combinational; io_in consumed this cycle.
- io_out  output  DATA_W  registered value of r7.
- io_out_valid  output  1  registered one-cycle pulse on each write to r7.
- instret  output  32  retired-instruction count; wraps mod 2^32.

## Operation
- State: r0–r6 (DATA_W), io_out (r7), pc (PC_W), ir (8), FSM {FETCH, EXEC, WAIT_IO}.
- FETCH: imem_req=1, imem_addr=pc; on imem_valid: ir<=imem_data, go EXEC. Otherwise hold.
- EXEC decodes ir[7:6]:
  - 00 immediate: r0 <= zero-extended ir[5:0].
  - 01 calculate: r3 <= ALU(ir[5:0], r1, r2).
  - 10 copy: r[ir[2:0]] <= r[ir[5:3]]. Source 7 reads io_in; destination 7 writes io_out and pulses io_out_valid.
  - 11 branch: if cond(ir[2:0], r3), pc <= r0[PC_W-1:0]; else pc <= pc+1.
- Non-branch instructions: pc <= pc+1, wrapping mod 2^PC_W.
- Copy with source 7 and io_in_valid=0 in EXEC: go WAIT_IO; no writes, pc and instret held.
- WAIT_IO: wait for io_in_valid, then complete exactly as EXEC.
- Completing cycle asserts io_in_ack=1 for exactly that one cycle.
- Every completed instruction: instret+1, go FETCH.
- ALU ops, modulo 2^DATA_W:
  - 0 OR, 1 NAND, 2 NOR, 3 AND, 4 ADD, 5 SUB (r1−r2), 6 XOR.
  - 7 SHL, 8 SHR logical, 9 ASR; shift amount = full r2 value; amount ≥ DATA_W gives 0 (ASR: all bits equal to sign).
  - 10–63 give 0, still written to r3.
- Conditions on r3, signed by bit DATA_W-1: 0 never, 1 ==0, 2 <0, 3 ≤0, 4 always, 5 ≠0, 6 ≥0, 7 >0.

## Timing
- Reset (cycle with reset=1):
  - pc=RESET_PC, r0–r6=0, io_out=0, io_out_valid=0, instret=0, FSM=FETCH.
  - imem_req=0, io_in_ack=0; imem_valid and io_in_valid are ignored.
- Reset wins over any in-flight fetch or WAIT_IO: instruction abandoned, no ack, no write.
- Zero-wait memory: 2 cycles per instruction (FETCH, EXEC). Each imem_valid stall cycle adds 1; each cycle in WAIT_IO adds 1.
- imem_addr stays stable while imem_req is high and imem_valid is low.
- Register writes, pc and instret update at the posedge ending the completing cycle.
- io_out and io_out_valid change at that same posedge and are visible the next cycle.
- io_out_valid is high for exactly one cycle per write to r7, including copy r7→r7, which echoes io_in to io_out.
- No other simultaneous events exist: one instruction is in flight at a time.

## Test plan
- Reset: hold reset 3 cycles with imem_valid=1 -> all outputs at reset values. Release -> next cycle imem_req=1, imem_addr=RESET_PC.
- Immediate/output, DATA_W=8: program 0x2A, 0x87 -> io_out=0x2A with a single io_out_valid pulse 4 cycles after the first fetch; instret=2.
- Arithmetic, DATA_W=16: r1=3, r2=5, op 0x45 -> r3=0xFFFE. Op 0x47 with r2=16 -> r3=0. Op 0x49 on r1=0x8000, r2=4 -> r3=0xF800.
- Branch: r3=0xFE, r0=10, op 0xC2 -> imem_addr=10. Same with op 0xC7 -> imem_addr=pc+1. pc=0xFF non-branch -> wraps to 0x00.
- I/O stall: op 0xB8 with io_in_valid low for 5 cycles -> imem_req=0, io_in_ack=0, instret frozen. Then io_in=0x77 valid -> io_in_ack for 1 cycle, r0=0x77, instret+1.
- Memory stall and reset: delay imem_valid 3 cycles -> imem_addr stable throughout. Assert reset during WAIT_IO -> no ack, pc=RESET_PC.

Source files
------------

// File: rtl/interlude_core.sv
// rtl/interlude_core.sv - multicycle 8-bit-encoded CPU core with stalling fetch and flow-controlled r7 I/O
module interlude_core #(
  parameter int DATA_W   = 8,
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_valid,
  input  logic [7:0]        imem_data,
  input  logic [DATA_W-1:0] io_in,
  input  logic              io_in_valid,
  output logic              io_in_ack,
  output logic [DATA_W-1:0] io_out,
  output logic              io_out_valid,
  output logic [31:0]       instret
);

  localparam logic [1:0] S_FETCH   = 2'd0;
  localparam logic [1:0] S_EXEC    = 2'd1;
  localparam logic [1:0] S_WAIT_IO = 2'd2;
  localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

  logic [1:0]        r_state;
  logic [PC_W-1:0]   r_pc;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_regs [0:6];
  logic [DATA_W-1:0] r_io_out;
  logic              r_io_out_valid;
  logic [31:0]       r_instret;

  logic [1:0]        w_op;
  logic [2:0]        w_src;
  logic [2:0]        w_dst;
  logic              w_active;
  logic              w_src_io;
  logic              w_complete;
  logic [DATA_W-1:0] w_src_val;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W-1:0] w_r3;
  logic [DATA_W-1:0] w_alu;
  logic              w_neg;
  logic              w_zero;
  logic              w_take;

  assign w_op  = r_ir[7:6];
  assign w_src = r_ir[5:3];
  assign w_dst = r_ir[2:0];
  assign w_a   = r_regs[1];
  assign w_b   = r_regs[2];
  assign w_r3  = r_regs[3];

  assign w_active   = (r_state == S_EXEC) || (r_state == S_WAIT_IO);
  assign w_src_io   = (w_op == 2'b10) && (w_src == 3'd7);
  // A copy from r7 can only complete once the input port holds a value.
  assign w_complete = w_active && !(w_src_io && !io_in_valid);

  assign imem_req     = (r_state == S_FETCH) && !reset;
  assign imem_addr    = r_pc;
  assign io_in_ack    = w_complete && w_src_io && !reset;
  assign io_out       = r_io_out;
  assign io_out_valid = r_io_out_valid;
  assign instret      = r_instret;

  always_comb begin
    w_src_val = io_in;
    if (w_src != 3'd7) w_src_val = r_regs[w_src];
  end

  // Shifts by the full r2 value naturally yield 0 (or sign fill) past DATA_W.
  always_comb begin
    w_alu = '0;
    case (r_ir[5:0])
      6'd0:    w_alu = w_a | w_b;
      6'd1:    w_alu = ~(w_a & w_b);
      6'd2:    w_alu = ~(w_a | w_b);
      6'd3:    w_alu = w_a & w_b;
      6'd4:    w_alu = w_a + w_b;
      6'd5:    w_alu = w_a - w_b;
      6'd6:    w_alu = w_a ^ w_b;
      6'd7:    w_alu = w_a << w_b;
      6'd8:    w_alu = w_a >> w_b;
      6'd9:    w_alu = $unsigned($signed(w_a) >>> w_b);
      default: w_alu = '0;
    endcase
  end

  assign w_neg  = w_r3[DATA_W-1];
  assign w_zero = (w_r3 == '0);

  always_comb begin
    w_take = 1'b0;
    case (r_ir[2:0])
      3'd0: w_take = 1'b0;
      3'd1: w_take = w_zero;
      3'd2: w_take = w_neg;
      3'd3: w_take = w_neg || w_zero;
      3'd4: w_take = 1'b1;
      3'd5: w_take = !w_zero;
      3'd6: w_take = !w_neg;
      3'd7: w_take = !w_neg && !w_zero;
      default: w_take = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_pc           <= LP_RESET_PC;
      r_ir           <= '0;
      for (int i = 0; i < 7; i++) r_regs[i] <= '0;
      r_io_out       <= '0;
      r_io_out_valid <= 1'b0;
      r_instret      <= '0;
    end else begin
      r_io_out_valid <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (imem_valid) begin
            r_ir    <= imem_data;
            r_state <= S_EXEC;
          end
        end
        S_EXEC, S_WAIT_IO: begin
          if (w_complete) begin
            case (w_op)
              2'b00: r_regs[0] <= {{(DATA_W-6){1'b0}}, r_ir[5:0]};
              2'b01: r_regs[3] <= w_alu;
              2'b10: begin
                if (w_dst == 3'd7) begin
                  r_io_out       <= w_src_val;
                  r_io_out_valid <= 1'b1;
                end else begin
                  r_regs[w_dst] <= w_src_val;
                end
              end
              default: ;
            endcase
            r_pc      <= (w_op == 2'b11 && w_take) ? r_regs[0][PC_W-1:0] : r_pc + 1'b1;
            r_instret <= r_instret + 32'd1;
            r_state   <= S_FETCH;
          end else begin
            r_state <= S_WAIT_IO;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_interlude_core.sv
// tb/tb_interlude_core.sv - scoreboard bench for interlude_core against an ISA-level reference model
module tb_interlude_core;
  localparam int DW  = 16;
  localparam int PW  = 8;
  localparam int RPC = 0;

  logic          clk = 1'b0;
  logic          reset;
  logic          imem_req;
  logic [PW-1:0] imem_addr;
  logic          imem_valid;
  logic [7:0]    imem_data;
  logic [DW-1:0] io_in;
  logic          io_in_valid;
  logic          io_in_ack;
  logic [DW-1:0] io_out;
  logic          io_out_valid;
  logic [31:0]   instret;

  always #5 clk = ~clk;

  interlude_core #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_data(imem_data),
    .io_in(io_in), .io_in_valid(io_in_valid), .io_in_ack(io_in_ack),
    .io_out(io_out), .io_out_valid(io_out_valid), .instret(instret)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]  q_addr [$];
  logic [31:0] q_iret [$];
  logic [15:0] q_out  [$];
  logic [15:0] q_ack  [$];

  logic [15:0] m_r [8];
  logic [7:0]  m_pc;
  logic [31:0] m_instret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [15:0] ref_alu(input int op, input logic [15:0] a, input logic [15:0] b);
    longint sa, p, q;
    case (op)
      0: return a | b;
      1: return ~(a & b);
      2: return ~(a | b);
      3: return a & b;
      4: return a + b;
      5: return a - b;
      6: return a ^ b;
      7: begin
        if (b >= 16) return 16'h0;
        return 16'((longint'(a) * (longint'(1) << b)) % 65536);
      end
      8: begin
        if (b >= 16) return 16'h0;
        return 16'(longint'(a) / (longint'(1) << b));
      end
      9: begin
        sa = a[15] ? longint'(a) - 65536 : longint'(a);
        if (b >= 16) return a[15] ? 16'hFFFF : 16'h0;
        p = longint'(1) << b;
        q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        return 16'(q);
      end
      default: return 16'h0;
    endcase
  endfunction

  function automatic bit ref_cond(input int c, input logic [15:0] v);
    int s;
    s = v[15] ? int'(v) - 65536 : int'(v);
    case (c)
      0: return 1'b0;
      1: return s == 0;
      2: return s < 0;
      3: return s <= 0;
      4: return 1'b1;
      5: return s != 0;
      6: return s >= 0;
      default: return s > 0;
    endcase
  endfunction

  task automatic model_reset();
    m_pc = 8'(RPC);
    m_instret = 0;
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
  endtask

  task automatic model_step(input logic [7:0] ins, input logic [15:0] ioval);
    logic [15:0] v;
    bit take;
    take = 1'b0;
    case (ins[7:6])
      2'b00: m_r[0] = 16'(ins[5:0]);
      2'b01: m_r[3] = ref_alu(int'(ins[5:0]), m_r[1], m_r[2]);
      2'b10: begin
        v = (ins[5:3] == 3'd7) ? ioval : m_r[ins[5:3]];
        if (ins[2:0] == 3'd7) q_out.push_back(v);
        m_r[ins[2:0]] = v;
      end
      default: take = ref_cond(int'(ins[2:0]), m_r[3]);
    endcase
    m_pc = take ? m_r[0][7:0] : m_pc + 8'd1;
    m_instret = m_instret + 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Entered mid-cycle with the core in FETCH; returns mid-cycle of the next FETCH.
  task automatic do_instr(input logic [7:0] ins, input int istall, input int iostall, input logic [15:0] ioval);
    bit is_io;
    is_io = (ins[7:6] == 2'b10) && (ins[5:3] == 3'd7);
    q_addr.push_back(m_pc);
    q_iret.push_back(m_instret);
    if (is_io) q_ack.push_back(ioval);
    for (int s = 0; s < istall; s++) begin
      imem_valid = 1'b0; imem_data = 8'($urandom); io_in_valid = 1'($urandom); io_in = 16'($urandom);
      cyc();
    end
    imem_valid = 1'b1; imem_data = ins; io_in_valid = 1'($urandom);
    cyc();
    imem_valid = 1'($urandom); imem_data = 8'($urandom);
    if (is_io) begin
      for (int s = 0; s < iostall; s++) begin
        io_in_valid = 1'b0; io_in = 16'($urandom);
        #1;
        chk("wait_imem_req", imem_req, 1'b0);
        chk("wait_ack", io_in_ack, 1'b0);
        chk("wait_instret", instret, m_instret);
        cyc();
      end
      io_in_valid = 1'b1; io_in = ioval;
      cyc();
    end else begin
      io_in_valid = 1'($urandom); io_in = 16'($urandom);
      cyc();
    end
    imem_valid = 1'b0; io_in_valid = 1'b0;
    model_step(ins, ioval);
  endtask

  logic [7:0]  mon_a;
  logic [31:0] mon_i;
  logic [15:0] mon_v;

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && imem_valid) begin
        if (q_addr.size() == 0) chk("fetch_unexpected", q_addr.size(), 1);
        else begin
          mon_a = q_addr.pop_front();
          mon_i = q_iret.pop_front();
          chk("fetch_addr", imem_addr, mon_a);
          chk("fetch_instret", instret, mon_i);
        end
      end else if (imem_req && q_addr.size() != 0) begin
        chk("addr_stable", imem_addr, q_addr[0]);
      end
      if (io_out_valid) begin
        if (q_out.size() == 0) chk("out_unexpected", q_out.size(), 1);
        else begin
          mon_v = q_out.pop_front();
          chk("io_out", io_out, mon_v);
        end
      end
      if (io_in_ack) begin
        if (q_ack.size() == 0) chk("ack_unexpected", q_ack.size(), 1);
        else begin
          mon_v = q_ack.pop_front();
          chk("ack_data", io_in, mon_v);
        end
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ins;
    int kind;
    reset = 1'b1; imem_valid = 1'b1; imem_data = 8'h2A; io_in_valid = 1'b1; io_in = 16'h1234;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_ack", io_in_ack, 1'b0);
    end
    chk("rst_io_out", io_out, 16'h0);
    chk("rst_io_out_valid", io_out_valid, 1'b0);
    chk("rst_instret", instret, 32'h0);
    reset = 1'b0; imem_valid = 1'b0; io_in_valid = 1'b0;
    #1;
    chk("rel_imem_req", imem_req, 1'b1);
    chk("rel_imem_addr", imem_addr, RPC);

    do_instr(8'h2A, 0, 0, 16'h0);
    do_instr(8'h87, 0, 0, 16'h0);
    chk("imm_out_valid_c4", io_out_valid, 1'b1);
    chk("imm_out", io_out, 16'h002A);
    chk("imm_instret", instret, 32'd2);

    do_instr(8'h03, 0, 0, 0); do_instr(8'h81, 0, 0, 0);
    do_instr(8'h05, 0, 0, 0); do_instr(8'h82, 0, 0, 0);
    do_instr(8'h45, 0, 0, 0); do_instr(8'h9F, 0, 0, 0);
    chk("sub_r3", io_out, 16'hFFFE);
    do_instr(8'h10, 0, 0, 0); do_instr(8'h82, 0, 0, 0);
    do_instr(8'h47, 0, 0, 0); do_instr(8'h9F, 0, 0, 0);
    chk("shl_by_16", io_out, 16'h0000);
    do_instr(8'hB9, 0, 0, 16'h8000); do_instr(8'h04, 0, 0, 0); do_instr(8'h82, 0, 0, 0);
    do_instr(8'h49, 0, 0, 0); do_instr(8'h9F, 0, 0, 0);
    chk("asr_r3", io_out, 16'hF800);

    do_instr(8'h0A, 0, 0, 0); do_instr(8'hC2, 0, 0, 0);
    chk("branch_taken", imem_addr, 8'd10);
    do_instr(8'hC7, 0, 0, 0);
    chk("branch_not_taken", imem_addr, 8'd11);
    do_instr(8'hB8, 0, 0, 16'h00FF); do_instr(8'hC4, 0, 0, 0);
    chk("branch_to_ff", imem_addr, 8'hFF);
    do_instr(8'h00, 0, 0, 0);
    chk("pc_wrap", imem_addr, 8'h00);

    do_instr(8'hB8, 0, 5, 16'h0077);
    do_instr(8'h87, 0, 0, 0);
    chk("io_stall_r0", io_out, 16'h0077);
    do_instr(8'h01, 3, 0, 0);

    q_addr.push_back(m_pc);
    q_iret.push_back(m_instret);
    imem_valid = 1'b1; imem_data = 8'hB8;
    cyc();
    imem_valid = 1'b0; io_in_valid = 1'b0;
    for (int s = 0; s < 3; s++) cyc();
    chk("abort_no_ack", io_in_ack, 1'b0);
    reset = 1'b1; io_in_valid = 1'b1; io_in = 16'h5555;
    #1;
    chk("abort_rst_ack", io_in_ack, 1'b0);
    chk("abort_rst_req", imem_req, 1'b0);
    cyc();
    reset = 1'b0; io_in_valid = 1'b0;
    #1;
    model_reset();
    chk("abort_pc", imem_addr, RPC);
    chk("abort_instret", instret, 32'h0);
    chk("abort_io_out", io_out, 16'h0);

    for (int k = 0; k < 300; k++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: ins = 8'($urandom);
        1: ins = {2'b10, 3'($urandom), 3'd7};
        2: ins = {2'b00, 6'($urandom)};
        3: ins = {2'b01, 6'($urandom_range(0, 11))};
        default: ins = {2'b10, 3'd7, 3'($urandom_range(1, 2))};
      endcase
      do_instr(ins, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
               int'($urandom_range(0, 3)),
               ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 19)) : 16'($urandom));
      if (kind == 3) do_instr(8'h9F, 0, 0, 0);
    end

    cyc(); cyc();
    chk("end_q_out", q_out.size(), 0);
    chk("end_q_ack", q_ack.size(), 0);
    chk("end_instret", instret, m_instret);
    chk("end_io_out", io_out, m_r[7]);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
